// File: rtl/axi_lite_write_manager.sv
// AXI4-Lite write subordinate: captures AW and W, updates a bank of NUM_REGS registers, returns B.
// Define AXI_LITE_WRITE_STROBE_EN to honour write_data_strobe per byte lane; otherwise writes replace the whole word.
module axi_lite_write_manager #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int WRITE_STROBE = DATA_SIZE / 8,
    parameter int NUM_REGS     = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [ADDRESS_SIZE-1:0]       write_address,
    input  logic                          write_address_valid,
    output logic                          write_address_ready,
    input  logic [DATA_SIZE-1:0]          write_data,
    input  logic [WRITE_STROBE-1:0]       write_data_strobe,
    input  logic                          write_data_valid,
    output logic                          write_data_ready,
    output logic [1:0]                    write_response,
    output logic                          write_response_valid,
    input  logic                          write_response_ready,
    output logic [NUM_REGS*DATA_SIZE-1:0] register_data,
    output logic [NUM_REGS-1:0]           register_write_pulse
);
    localparam int LANE_BITS = $clog2(WRITE_STROBE);
    localparam int IDX_BITS  = $clog2(NUM_REGS);
    localparam logic [ADDRESS_SIZE-1:0] ADDR_LIMIT = ADDRESS_SIZE'(NUM_REGS * WRITE_STROBE);

    typedef enum logic [1:0] {INIT, IDLE, WRITE, RESP} state_t;

    state_t                  state_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0]    data_q;
    logic [DATA_SIZE-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]     pulse_q;
    logic                    awReady_q;
    logic                    wReady_q;
    logic                    bValid_q;
    logic [1:0]              bResp_q;

    logic                    awFire;
    logic                    wFire;
    logic                    inRange;
    logic [IDX_BITS-1:0]     regIndex;
    logic [DATA_SIZE-1:0]    word_d;

`ifdef AXI_LITE_WRITE_STROBE_EN
    logic [WRITE_STROBE-1:0] strobe_q;
`else
    logic                    unusedStrobe;
    assign unusedStrobe = ^write_data_strobe;
`endif

    assign awFire   = write_address_valid && awReady_q;
    assign wFire    = write_data_valid && wReady_q;
    assign regIndex = addr_q[LANE_BITS +: IDX_BITS];
    assign inRange  = (addr_q < ADDR_LIMIT);

    // Merge the captured data into the addressed register's current contents.
    always_comb begin
        word_d = regs_q[regIndex];
`ifdef AXI_LITE_WRITE_STROBE_EN
        for (int b = 0; b < WRITE_STROBE; b++) begin
            if (strobe_q[b]) begin
                word_d[b*8 +: 8] = data_q[b*8 +: 8];
            end
        end
`else
        word_d = data_q;
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= INIT;
            addr_q    <= '0;
            data_q    <= '0;
            pulse_q   <= '0;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bResp_q   <= 2'b00;
`ifdef AXI_LITE_WRITE_STROBE_EN
            strobe_q  <= '0;
`endif
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            case (state_q)
                INIT: begin
                    state_q   <= IDLE;
                    awReady_q <= 1'b1;
                    wReady_q  <= 1'b1;
                end
                IDLE: begin
                    if (awFire) begin
                        addr_q    <= write_address;
                        awReady_q <= 1'b0;
                    end
                    if (wFire) begin
                        data_q   <= write_data;
`ifdef AXI_LITE_WRITE_STROBE_EN
                        strobe_q <= write_data_strobe;
`endif
                        wReady_q <= 1'b0;
                    end
                    // A dropped ready means that channel was captured on an earlier edge.
                    if ((awFire || !awReady_q) && (wFire || !wReady_q)) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (inRange) begin
                        regs_q[regIndex] <= word_d;
                        pulse_q          <= NUM_REGS'(1) << regIndex;
                        bResp_q          <= 2'b00;
                    end else begin
                        pulse_q <= '0;
                        bResp_q <= 2'b10;
                    end
                    bValid_q <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    pulse_q <= '0;
                    if (write_response_ready) begin
                        bValid_q  <= 1'b0;
                        awReady_q <= 1'b1;
                        wReady_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign write_address_ready  = awReady_q;
    assign write_data_ready     = wReady_q;
    assign write_response       = bResp_q;
    assign write_response_valid = bValid_q;
    assign register_write_pulse = pulse_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regOut
        assign register_data[k*DATA_SIZE +: DATA_SIZE] = regs_q[k];
    end

endmodule

// File: tb/tb_axi_lite_write_manager.sv
// Self-checking bench for axi_lite_write_manager (default parameters, NUM_REGS=4, 32-bit data).
// Expected register images depend on whether AXI_LITE_WRITE_STROBE_EN is defined.
module tb_axi_lite_write_manager;
    logic         aclk = 1'b0;
    logic         areset;
    logic [31:0]  write_address;
    logic         write_address_valid;
    logic         write_address_ready;
    logic [31:0]  write_data;
    logic [3:0]   write_data_strobe;
    logic         write_data_valid;
    logic         write_data_ready;
    logic [1:0]   write_response;
    logic         write_response_valid;
    logic         write_response_ready;
    logic [127:0] register_data;
    logic [3:0]   register_write_pulse;

    int compared   = 0;
    int mismatched = 0;

    axi_lite_write_manager dut (
        .aclk                 (aclk),
        .areset               (areset),
        .write_address        (write_address),
        .write_address_valid  (write_address_valid),
        .write_address_ready  (write_address_ready),
        .write_data           (write_data),
        .write_data_strobe    (write_data_strobe),
        .write_data_valid     (write_data_valid),
        .write_data_ready     (write_data_ready),
        .write_response       (write_response),
        .write_response_valid (write_response_valid),
        .write_response_ready (write_response_ready),
        .register_data        (register_data),
        .register_write_pulse (register_write_pulse)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        int           wLead;
        logic [1:0]   expResp;
        logic [3:0]   expPulse;
        logic [127:0] expFull;
    } vec_t;

    vec_t vecs [8];

    // Register images {reg3, reg2, reg1, reg0} after each table entry, worked out by hand.
`ifdef AXI_LITE_WRITE_STROBE_EN
    localparam logic [127:0] FULL1 = 128'h00000000_00000000_DEADBEEF_00000000;
    localparam logic [127:0] FULL2 = 128'h00000000_00340078_DEADBEEF_00000000;
    localparam logic [127:0] FULL4 = 128'hA5000000_00340078_DEADBEEF_00000000;
    localparam logic [127:0] FULL5 = 128'hA5000000_00340078_DEAD3344_00000000;
    localparam logic [127:0] FULL6 = 128'hA5000000_00340078_DEAD3344_00000000;
    localparam logic [127:0] FULL8 = 128'hA50000EF_00340078_DEAD3344_00000000;
    localparam logic [127:0] FULLBP = 128'hA50000EF_00340078_0BADF00D_00000000;
`else
    localparam logic [127:0] FULL1 = 128'h00000000_00000000_DEADBEEF_00000000;
    localparam logic [127:0] FULL2 = 128'h00000000_12345678_DEADBEEF_00000000;
    localparam logic [127:0] FULL4 = 128'hA5A5A5A5_12345678_DEADBEEF_00000000;
    localparam logic [127:0] FULL5 = 128'hA5A5A5A5_12345678_11223344_00000000;
    localparam logic [127:0] FULL6 = 128'hA5A5A5A5_12345678_11223344_CAFEF00D;
    localparam logic [127:0] FULL8 = 128'h0000BEEF_12345678_11223344_CAFEF00D;
    localparam logic [127:0] FULLBP = 128'h0000BEEF_12345678_0BADF00D_CAFEF00D;
`endif

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present AW and W with W leading by wLead cycles (negative: AW leads); returns on the negedge after the later handshake.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int wLead);
        int awStart;
        int wStart;
        int cyc;
        bit awDone;
        bit wDone;
        bit awHs;
        bit wHs;
        awStart = (wLead > 0) ? wLead : 0;
        wStart  = (wLead < 0) ? -wLead : 0;
        awDone  = 1'b0;
        wDone   = 1'b0;
        cyc     = 0;
        write_address     = addr;
        write_data        = data;
        write_data_strobe = strb;
        while (!(awDone && wDone) && cyc < 40) begin
            write_address_valid = !awDone && (cyc >= awStart);
            write_data_valid    = !wDone && (cyc >= wStart);
            awHs = write_address_valid && write_address_ready;
            wHs  = write_data_valid && write_data_ready;
            @(negedge aclk);
            if (awHs) awDone = 1'b1;
            if (wHs)  wDone  = 1'b1;
            cyc++;
        end
        write_address_valid = 1'b0;
        write_data_valid    = 1'b0;
        if (!(awDone && wDone)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL handshake: aw=%0d w=%0d after %0d cycles, both required", awDone, wDone, cyc);
        end
    endtask

    initial begin
        areset               = 1'b1;
        write_address        = '0;
        write_address_valid  = 1'b0;
        write_data           = '0;
        write_data_strobe    = '0;
        write_data_valid     = 1'b0;
        write_response_ready = 1'b0;

        vecs[0] = '{32'h0000_0004, 32'hDEADBEEF, 4'hF,     0, 2'b00, 4'b0010, FULL1};
        vecs[1] = '{32'h0000_0008, 32'h12345678, 4'b0101,  3, 2'b00, 4'b0100, FULL2};
        vecs[2] = '{32'h0000_0010, 32'hFFFFFFFF, 4'hF,     0, 2'b10, 4'b0000, FULL2};
        vecs[3] = '{32'h0000_000C, 32'hA5A5A5A5, 4'b1000, -2, 2'b00, 4'b1000, FULL4};
        vecs[4] = '{32'h0000_0007, 32'h11223344, 4'b0011,  1, 2'b00, 4'b0010, FULL5};
        vecs[5] = '{32'h0000_0000, 32'hCAFEF00D, 4'b0000,  0, 2'b00, 4'b0001, FULL6};
        vecs[6] = '{32'h1000_0004, 32'h55555555, 4'hF,    -1, 2'b10, 4'b0000, FULL6};
        vecs[7] = '{32'h0000_000F, 32'h0000BEEF, 4'b0001,  0, 2'b00, 4'b1000, FULL8};

        // Reset held for three edges, then released.
        repeat (3) @(negedge aclk);
        checkOutput("resetRegs", register_data, 128'h0);
        checkOutput("resetCtl", {write_address_ready, write_data_ready, write_response_valid,
                                 write_response, register_write_pulse}, 9'h0);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("readiesAfterReset", {write_address_ready, write_data_ready}, 2'b11);

        write_response_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].wLead);
            checkOutput($sformatf("v%0d_writeState", i),
                        {write_response_valid, write_address_ready, write_data_ready}, 3'b000);
            @(negedge aclk);
            checkOutput($sformatf("v%0d_regs", i), register_data, vecs[i].expFull);
            checkOutput($sformatf("v%0d_pulse", i), register_write_pulse, vecs[i].expPulse);
            checkOutput($sformatf("v%0d_resp", i), {write_response_valid, write_response},
                        {1'b1, vecs[i].expResp});
            @(negedge aclk);
            checkOutput($sformatf("v%0d_done", i),
                        {register_write_pulse, write_response_valid, write_address_ready, write_data_ready},
                        7'b0000_011);
        end

        // Backpressure: B held for five cycles with both readies low.
        write_response_ready = 1'b0;
        applyStimulus(32'h0000_0004, 32'h0BADF00D, 4'hF, 0);
        @(negedge aclk);
        checkOutput("bpRegs", register_data, FULLBP);
        checkOutput("bpPulse", register_write_pulse, 4'b0010);
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            checkOutput($sformatf("bpHold%0d", c),
                        {register_write_pulse, write_response_valid, write_response,
                         write_address_ready, write_data_ready}, 9'b0000_1_00_00);
        end
        write_response_ready = 1'b1;
        @(negedge aclk);
        checkOutput("bpRelease", {write_response_valid, write_address_ready, write_data_ready}, 3'b011);

        // Reset while the response is pending aborts it and clears the bank.
        write_response_ready = 1'b0;
        applyStimulus(32'h0000_0000, 32'h11111111, 4'hF, 0);
        @(negedge aclk);
        checkOutput("rstRespPending", {write_response_valid, write_response}, 3'b100);
        areset = 1'b1;
        @(negedge aclk);
        checkOutput("rstRespRegs", register_data, 128'h0);
        checkOutput("rstRespCtl", {write_address_ready, write_data_ready, write_response_valid,
                                   write_response, register_write_pulse}, 9'h0);
        areset               = 1'b0;
        write_response_ready = 1'b1;
        @(negedge aclk);
        checkOutput("rstRespReadies", {write_address_ready, write_data_ready}, 2'b11);
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            checkOutput($sformatf("rstNoResp%0d", c), {write_response_valid, register_write_pulse}, 5'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
